// File: rtl/avs_uart_pkg.sv
// Shared constants and types for the avs_uart register map and the
// controller that sequences it.
package avs_uart_pkg;

  localparam int REG_RX   = 0;
  localparam int REG_TX   = 1;
  localparam int REG_CTRL = 2;
  localparam int REG_STAT = 3;
  localparam int REG_DIV  = 4;

  localparam int ST_RX_AVAIL = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_RX_OVR   = 2;

  localparam int CTRL_TX_EN  = 0;
  localparam int CTRL_RX_EN  = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam logic [7:0]  CTRL_MASK = 8'((1 << CTRL_TX_EN) | (1 << CTRL_RX_EN) | (1 << CTRL_IRQ_EN));
  localparam logic [31:0] OVR_CLEAR = 32'(1 << ST_RX_OVR);

  typedef enum logic [3:0] {
    CFG_DIV, CFG_CTRL, GAP, RD_STAT, DECIDE, RD_RX, WR_TX, CLR_OVR, WR_DIV
  } ctrl_state_e;

  typedef enum logic {SRV_RX, SRV_TX} srv_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/avm_uart_ctrl_if.sv
// Avalon-MM bus between the controller (master) and the UART slave port.
interface avm_uart_ctrl_if #(
  parameter int AW = 5,
  parameter int DW = 32
) ();
  logic [AW-1:0] avm_address;
  logic          avm_read;
  logic          avm_write;
  logic [DW-1:0] avm_writedata;
  logic [DW-1:0] avm_readdata;
  logic          avm_waitrequest;

  modport master (
    output avm_address, avm_read, avm_write, avm_writedata,
    input  avm_readdata, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_writedata,
    output avm_readdata, avm_waitrequest
  );
endinterface

// File: rtl/avm_single_xfer.sv
// Single-transaction Avalon-MM engine: latches a request, holds it through
// waitrequest, and flags completion combinationally on the finishing cycle.
module avm_single_xfer #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          is_write,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          done,
  output logic [DW-1:0] rdata,
  avm_uart_ctrl_if.master avm
);

  logic          rd_q, wr_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          busy;

  assign busy = rd_q | wr_q;

  // A new request is only taken while idle, so completion always leaves one
  // strobe-low cycle before the next transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (busy) begin
      if (!avm.avm_waitrequest) begin
        rd_q <= 1'b0;
        wr_q <= 1'b0;
      end
    end else if (start) begin
      rd_q    <= !is_write;
      wr_q    <= is_write;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

  assign avm.avm_read      = rd_q;
  assign avm.avm_write     = wr_q;
  assign avm.avm_address   = addr_q;
  assign avm.avm_writedata = wdata_q;
  assign done  = busy && !avm.avm_waitrequest;
  assign rdata = avm.avm_readdata;

endmodule

// File: rtl/avm_uart_ctrl.sv
// Avalon-MM master that initialises one avs_uart and then polls its status to
// move bytes between the UART data registers and two byte streams.
module avm_uart_ctrl
  import avs_uart_pkg::*;
#(
  parameter int          AW           = 5,
  parameter int          DW           = 32,
  parameter logic [31:0] CLK_DIV_INIT = 32'd434,
  parameter logic [7:0]  CTRL_INIT    = 8'h03,
  parameter int          POLL_GAP     = 16
) (
  input  logic        clk,
  input  logic        reset,
  avm_uart_ctrl_if.master avm,
  input  logic [7:0]  tx_in_data,
  input  logic        tx_in_valid,
  output logic        tx_in_ready,
  output logic [7:0]  rx_out_data,
  output logic        rx_out_valid,
  input  logic        rx_out_ready,
  input  logic [31:0] cfg_div,
  input  logic        cfg_div_wr,
  output logic        cfg_done,
  output logic [7:0]  ovr_count
);

  ctrl_state_e   state_q;
  srv_e          last_q;
  logic [15:0]   gap_q;
  logic [2:0]    stat_q;
  logic          div_pending_q;
  logic [31:0]   div_val_q;
  logic [7:0]    rx_out_data_q;
  logic          rx_out_valid_q;
  logic          tx_in_ready_q;
  logic          cfg_done_q;
  logic [7:0]    ovr_count_q;

  logic          xfer_start, xfer_wr, xfer_done;
  logic [AW-1:0] xfer_addr;
  logic [DW-1:0] xfer_wdata, xfer_rdata;
  logic          tx_work, rx_ok, gap_last;
  logic          unused_rdata;

  assign tx_work  = stat_q[ST_TX_EMPTY] && tx_in_valid;
  assign rx_ok    = stat_q[ST_RX_AVAIL] && !rx_out_valid_q;
  assign gap_last = ({1'b0, gap_q} + 17'd1) >= 17'(POLL_GAP);
  assign unused_rdata = ^xfer_rdata[DW-1:8];

  always_comb begin
    xfer_start = 1'b0;
    xfer_wr    = 1'b0;
    xfer_addr  = '0;
    xfer_wdata = '0;
    case (state_q)
      CFG_DIV:  begin xfer_start = 1'b1; xfer_wr = 1'b1; xfer_addr = AW'(REG_DIV);  xfer_wdata = DW'(CLK_DIV_INIT); end
      CFG_CTRL: begin xfer_start = 1'b1; xfer_wr = 1'b1; xfer_addr = AW'(REG_CTRL); xfer_wdata = DW'(CTRL_INIT & CTRL_MASK); end
      RD_STAT:  begin xfer_start = 1'b1; xfer_addr = AW'(REG_STAT); end
      RD_RX:    begin xfer_start = 1'b1; xfer_addr = AW'(REG_RX); end
      WR_TX:    begin xfer_start = 1'b1; xfer_wr = 1'b1; xfer_addr = AW'(REG_TX);   xfer_wdata = DW'(tx_in_data); end
      CLR_OVR:  begin xfer_start = 1'b1; xfer_wr = 1'b1; xfer_addr = AW'(REG_STAT); xfer_wdata = DW'(OVR_CLEAR); end
      WR_DIV:   begin xfer_start = 1'b1; xfer_wr = 1'b1; xfer_addr = AW'(REG_DIV);  xfer_wdata = DW'(div_val_q); end
      default: ;
    endcase
  end

  avm_single_xfer #(.AW(AW), .DW(DW)) u_xfer (
    .clk      (clk),
    .reset    (reset),
    .start    (xfer_start),
    .is_write (xfer_wr),
    .addr     (xfer_addr),
    .wdata    (xfer_wdata),
    .done     (xfer_done),
    .rdata    (xfer_rdata),
    .avm      (avm)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= CFG_DIV;
      last_q         <= SRV_RX;
      gap_q          <= '0;
      stat_q         <= '0;
      div_pending_q  <= 1'b0;
      div_val_q      <= '0;
      rx_out_data_q  <= '0;
      rx_out_valid_q <= 1'b0;
      tx_in_ready_q  <= 1'b0;
      cfg_done_q     <= 1'b0;
      ovr_count_q    <= '0;
    end else begin
      tx_in_ready_q <= 1'b0;
      if (rx_out_valid_q && rx_out_ready) rx_out_valid_q <= 1'b0;
      if (state_q != GAP) gap_q <= '0;
      case (state_q)
        CFG_DIV:  if (xfer_done) state_q <= CFG_CTRL;
        CFG_CTRL: if (xfer_done) begin cfg_done_q <= 1'b1; state_q <= GAP; end
        GAP: begin
          gap_q <= gap_q + 16'd1;
          if (gap_last) state_q <= RD_STAT;
        end
        RD_STAT:  if (xfer_done) begin stat_q <= xfer_rdata[2:0]; state_q <= DECIDE; end
        // Alternate RX/TX when both have work; never read RX over an undrained byte.
        DECIDE: begin
          if (div_pending_q)                                state_q <= WR_DIV;
          else if (stat_q[ST_RX_OVR])                       state_q <= CLR_OVR;
          else if (rx_ok && (last_q == SRV_TX || !tx_work)) state_q <= RD_RX;
          else if (tx_work)                                 state_q <= WR_TX;
          else if (rx_ok)                                   state_q <= RD_RX;
          else                                              state_q <= GAP;
        end
        RD_RX: if (xfer_done) begin
          rx_out_data_q  <= xfer_rdata[7:0];
          rx_out_valid_q <= 1'b1;
          last_q         <= SRV_RX;
          state_q        <= GAP;
        end
        WR_TX: if (xfer_done) begin
          tx_in_ready_q <= 1'b1;
          last_q        <= SRV_TX;
          state_q       <= GAP;
        end
        CLR_OVR: if (xfer_done) begin
          ovr_count_q       <= sat_inc8(ovr_count_q);
          stat_q[ST_RX_OVR] <= 1'b0;
          state_q           <= DECIDE;
        end
        WR_DIV: if (xfer_done) begin div_pending_q <= 1'b0; state_q <= GAP; end
        default: state_q <= CFG_DIV;
      endcase
      // A new request wins over a completion in the same cycle.
      if (cfg_div_wr) begin
        div_val_q     <= cfg_div;
        div_pending_q <= 1'b1;
      end
    end
  end

  assign tx_in_ready  = tx_in_ready_q;
  assign rx_out_data  = rx_out_data_q;
  assign rx_out_valid = rx_out_valid_q;
  assign cfg_done     = cfg_done_q;
  assign ovr_count    = ovr_count_q;

endmodule

// File: tb/tb_avm_uart_ctrl.sv
// Bench for avm_uart_ctrl: a UART slave model with 3 wait states per transfer
// and a scoreboard of expected bus transactions.
module tb_avm_uart_ctrl;

  typedef struct packed {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  tx_in_data;
  logic        tx_in_valid;
  logic        tx_in_ready;
  logic [7:0]  rx_out_data;
  logic        rx_out_valid;
  logic        rx_out_ready;
  logic [31:0] cfg_div;
  logic        cfg_div_wr;
  logic        cfg_done;
  logic [7:0]  ovr_count;

  logic [31:0] stat_val;
  logic [7:0]  rx_byte;
  int          wcnt;
  int          checks = 0;
  int          errors = 0;
  txn_t        exp_q[$];

  always #5 clk = ~clk;

  avm_uart_ctrl_if #(.AW(5), .DW(32)) bus ();

  avm_uart_ctrl #(
    .AW(5), .DW(32), .CLK_DIV_INIT(32'd434), .CTRL_INIT(8'h03), .POLL_GAP(2)
  ) dut (
    .clk          (clk),
    .reset        (rst),
    .avm          (bus),
    .tx_in_data   (tx_in_data),
    .tx_in_valid  (tx_in_valid),
    .tx_in_ready  (tx_in_ready),
    .rx_out_data  (rx_out_data),
    .rx_out_valid (rx_out_valid),
    .rx_out_ready (rx_out_ready),
    .cfg_div      (cfg_div),
    .cfg_div_wr   (cfg_div_wr),
    .cfg_done     (cfg_done),
    .ovr_count    (ovr_count)
  );

  // Slave model: every transfer stalls for exactly 3 cycles.
  assign bus.avm_waitrequest = (bus.avm_read || bus.avm_write) && (wcnt != 3);
  assign bus.avm_readdata = (bus.avm_address == 5'd3) ? stat_val :
                            (bus.avm_address == 5'd0) ? {24'h0, rx_byte} : 32'h0;

  always @(posedge clk) begin
    if (rst) wcnt <= 0;
    else if (bus.avm_waitrequest) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  function automatic txn_t mk(input logic wr, input logic [4:0] a, input logic [31:0] d);
    mk = {wr, a, d};
  endfunction

  // Waits for the next completing transaction; returns #1 after its completion edge.
  task automatic get_txn(output bit ok, output txn_t t);
    ok = 1'b0;
    t  = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if ((bus.avm_read || bus.avm_write) && !bus.avm_waitrequest) begin
        t.wr   = bus.avm_write;
        t.addr = bus.avm_address;
        t.data = bus.avm_write ? bus.avm_writedata : bus.avm_readdata;
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    txn_t got, e;
    bit ok;
    rst = 1'b1; tx_in_valid = 1'b0; tx_in_data = 8'h00; rx_out_ready = 1'b0;
    cfg_div = 32'h0; cfg_div_wr = 1'b0; stat_val = 32'h0; rx_byte = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.avm_read, bus.avm_write, bus.avm_address, bus.avm_writedata} !== '0) begin
      errors++;
      $display("FAIL reset_bus: rd=%b wr=%b addr=%0d wdata=%h, expected all zero",
               bus.avm_read, bus.avm_write, bus.avm_address, bus.avm_writedata);
    end
    checks++;
    if ({tx_in_ready, rx_out_valid, rx_out_data} !== 10'h0) begin
      errors++;
      $display("FAIL reset_streams: tx_in_ready=%b rx_out_valid=%b rx_out_data=%h, expected zeros",
               tx_in_ready, rx_out_valid, rx_out_data);
    end
    checks++;
    if ({cfg_done, ovr_count} !== 9'h0) begin
      errors++;
      $display("FAIL reset_cfg: cfg_done=%b ovr_count=%h, expected 0/00", cfg_done, ovr_count);
    end
    rst = 1'b0;
    exp_q.push_back(mk(1'b1, 5'd4, 32'd434));
    exp_q.push_back(mk(1'b1, 5'd2, 32'h3));
    for (int s = 0; s < 2; s++) begin
      get_txn(ok, got);
      e = exp_q.pop_front();
      checks++;
      if (!ok || got !== e) begin
        errors++;
        $display("FAIL init_write: got wr=%0d addr=%0d data=%h ok=%0d, expected wr=%0d addr=%0d data=%h",
                 got.wr, got.addr, got.data, ok, e.wr, e.addr, e.data);
      end
      checks++;
      if (cfg_done !== logic'(s == 1)) begin
        errors++;
        $display("FAIL cfg_done: after init write %0d got %b, expected %b", s, cfg_done, s == 1);
      end
    end
  endtask

  task automatic test_rx();
    txn_t got, e;
    bit ok;
    stat_val = 32'h1; rx_byte = 8'hC3; rx_out_ready = 1'b0;
    exp_q.push_back(mk(1'b0, 5'd3, 32'h1));
    exp_q.push_back(mk(1'b0, 5'd0, 32'hC3));
    for (int s = 0; s < 3; s++) exp_q.push_back(mk(1'b0, 5'd3, 32'h1));
    for (int s = 0; s < 5; s++) begin
      get_txn(ok, got);
      e = exp_q.pop_front();
      checks++;
      if (!ok || got !== e) begin
        errors++;
        $display("FAIL rx_seq[%0d]: got wr=%0d addr=%0d data=%h ok=%0d, expected wr=%0d addr=%0d data=%h",
                 s, got.wr, got.addr, got.data, ok, e.wr, e.addr, e.data);
      end
      if (s == 1) begin
        checks++;
        if ({rx_out_valid, rx_out_data} !== 9'h1C3) begin
          errors++;
          $display("FAIL rx_load: valid=%b data=%h, expected 1/c3", rx_out_valid, rx_out_data);
        end
      end
    end
    checks++;
    if ({rx_out_valid, rx_out_data} !== 9'h1C3) begin
      errors++;
      $display("FAIL rx_hold: valid=%b data=%h, expected 1/c3", rx_out_valid, rx_out_data);
    end
    rx_out_ready = 1'b1;
    @(posedge clk);
    #1;
    rx_out_ready = 1'b0;
    stat_val = 32'h0;
    checks++;
    if (rx_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rx_drain: valid=%b, expected 0", rx_out_valid);
    end
    exp_q.push_back(mk(1'b0, 5'd3, 32'h0));
    get_txn(ok, got);
    e = exp_q.pop_front();
    checks++;
    if (!ok || got !== e) begin
      errors++;
      $display("FAIL rx_after: got wr=%0d addr=%0d data=%h ok=%0d, expected wr=%0d addr=%0d data=%h",
               got.wr, got.addr, got.data, ok, e.wr, e.addr, e.data);
    end
  endtask

  task automatic test_tx();
    txn_t got, e;
    bit ok;
    stat_val = 32'h2; tx_in_data = 8'h5A; tx_in_valid = 1'b1;
    exp_q.push_back(mk(1'b0, 5'd3, 32'h2));
    exp_q.push_back(mk(1'b1, 5'd1, 32'h5A));
    exp_q.push_back(mk(1'b0, 5'd3, 32'h0));
    exp_q.push_back(mk(1'b0, 5'd3, 32'h0));
    exp_q.push_back(mk(1'b0, 5'd3, 32'h2));
    exp_q.push_back(mk(1'b1, 5'd1, 32'h77));
    for (int s = 0; s < 6; s++) begin
      get_txn(ok, got);
      e = exp_q.pop_front();
      checks++;
      if (!ok || got !== e) begin
        errors++;
        $display("FAIL tx_seq[%0d]: got wr=%0d addr=%0d data=%h ok=%0d, expected wr=%0d addr=%0d data=%h",
                 s, got.wr, got.addr, got.data, ok, e.wr, e.addr, e.data);
      end
      if (s == 1) begin
        checks++;
        if (tx_in_ready !== 1'b1) begin
          errors++;
          $display("FAIL tx_ready_pulse: got %b, expected 1", tx_in_ready);
        end
        // New byte offered while the UART reports busy: must wait for tx_empty.
        tx_in_data = 8'h77;
        stat_val = 32'h0;
        @(posedge clk);
        #1;
        checks++;
        if (tx_in_ready !== 1'b0) begin
          errors++;
          $display("FAIL tx_ready_width: got %b one cycle later, expected 0", tx_in_ready);
        end
      end
      if (s == 3) stat_val = 32'h2;
      if (s == 5) begin tx_in_valid = 1'b0; stat_val = 32'h0; end
    end
  endtask

  task automatic test_alternate();
    txn_t got, e;
    bit ok;
    logic [7:0] tx_cur;
    tx_cur = 8'h10;
    tx_in_data = tx_cur; tx_in_valid = 1'b1; stat_val = 32'h3;
    for (int k = 0; k < 4; k++) begin
      rx_byte = 8'hA0 + 8'(k);
      exp_q.push_back(mk(1'b0, 5'd3, 32'h3));
      if (k % 2 == 0) exp_q.push_back(mk(1'b0, 5'd0, {24'h0, rx_byte}));
      else            exp_q.push_back(mk(1'b1, 5'd1, {24'h0, tx_cur}));
      for (int s = 0; s < 2; s++) begin
        get_txn(ok, got);
        e = exp_q.pop_front();
        checks++;
        if (!ok || got !== e) begin
          errors++;
          $display("FAIL alt_order[%0d.%0d]: got wr=%0d addr=%0d data=%h ok=%0d, expected wr=%0d addr=%0d data=%h",
                   k, s, got.wr, got.addr, got.data, ok, e.wr, e.addr, e.data);
        end
      end
      if (k % 2 == 0) begin
        checks++;
        if ({rx_out_valid, rx_out_data} !== {1'b1, rx_byte}) begin
          errors++;
          $display("FAIL alt_rx[%0d]: valid=%b data=%h, expected 1/%h", k, rx_out_valid, rx_out_data, rx_byte);
        end
        rx_out_ready = 1'b1;
        @(posedge clk);
        #1;
        rx_out_ready = 1'b0;
      end else begin
        checks++;
        if (tx_in_ready !== 1'b1) begin
          errors++;
          $display("FAIL alt_tx[%0d]: tx_in_ready=%b, expected 1", k, tx_in_ready);
        end
        tx_cur = tx_cur + 8'd1;
        tx_in_data = tx_cur;
      end
    end
    tx_in_valid = 1'b0;
    stat_val = 32'h0;
  endtask

  task automatic test_overrun();
    txn_t got, e;
    bit ok;
    int exp_ovr;
    exp_ovr = 0;
    stat_val = 32'h4;
    for (int i = 1; i <= 300; i++) begin
      exp_q.push_back(mk(1'b0, 5'd3, 32'h4));
      exp_q.push_back(mk(1'b1, 5'd3, 32'h4));
      for (int s = 0; s < 2; s++) begin
        get_txn(ok, got);
        e = exp_q.pop_front();
        checks++;
        if (!ok || got !== e) begin
          errors++;
          $display("FAIL ovr_seq[%0d.%0d]: got wr=%0d addr=%0d data=%h ok=%0d, expected wr=%0d addr=%0d data=%h",
                   i, s, got.wr, got.addr, got.data, ok, e.wr, e.addr, e.data);
        end
      end
      exp_ovr = (exp_ovr < 255) ? exp_ovr + 1 : 255;
      checks++;
      if (ovr_count !== 8'(exp_ovr)) begin
        errors++;
        $display("FAIL ovr_count[%0d]: got %0d, expected %0d", i, ovr_count, exp_ovr);
      end
    end
    stat_val = 32'h0;
    exp_q.push_back(mk(1'b0, 5'd3, 32'h0));
    get_txn(ok, got);
    e = exp_q.pop_front();
    checks++;
    if (!ok || got !== e) begin
      errors++;
      $display("FAIL ovr_after: got wr=%0d addr=%0d data=%h ok=%0d, expected wr=%0d addr=%0d data=%h",
               got.wr, got.addr, got.data, ok, e.wr, e.addr, e.data);
    end
    checks++;
    if (ovr_count !== 8'hFF) begin
      errors++;
      $display("FAIL ovr_sat: got %h, expected ff", ovr_count);
    end
  endtask

  task automatic test_cfg_div();
    txn_t got, e;
    bit ok;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if ({cfg_done, ovr_count} !== 9'h0) begin
      errors++;
      $display("FAIL div_reset: cfg_done=%b ovr_count=%h, expected 0/00", cfg_done, ovr_count);
    end
    rst = 1'b0;
    exp_q.push_back(mk(1'b1, 5'd4, 32'd434));
    exp_q.push_back(mk(1'b1, 5'd2, 32'h3));
    exp_q.push_back(mk(1'b0, 5'd3, 32'h0));
    exp_q.push_back(mk(1'b1, 5'd4, 32'h36));
    exp_q.push_back(mk(1'b0, 5'd3, 32'h0));
    exp_q.push_back(mk(1'b0, 5'd3, 32'h0));
    for (int s = 0; s < 6; s++) begin
      get_txn(ok, got);
      e = exp_q.pop_front();
      checks++;
      if (!ok || got !== e) begin
        errors++;
        $display("FAIL div_seq[%0d]: got wr=%0d addr=%0d data=%h ok=%0d, expected wr=%0d addr=%0d data=%h",
                 s, got.wr, got.addr, got.data, ok, e.wr, e.addr, e.data);
      end
      if (s == 0) begin
        // Two back-to-back requests while CFG_CTRL is still in flight.
        cfg_div = 32'h1B; cfg_div_wr = 1'b1;
        @(posedge clk);
        #1;
        cfg_div = 32'h36;
        @(posedge clk);
        #1;
        cfg_div_wr = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid();
    txn_t got, e;
    bit ok;
    bit found;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.avm_write && bus.avm_waitrequest) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mid_write_seen: no stalled write within 20 cycles, expected one");
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if ({bus.avm_write, bus.avm_read} !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset_drop: wr=%b rd=%b after reset edge, expected 0/0", bus.avm_write, bus.avm_read);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.push_back(mk(1'b1, 5'd4, 32'd434));
    exp_q.push_back(mk(1'b1, 5'd2, 32'h3));
    exp_q.push_back(mk(1'b0, 5'd3, 32'h0));
    exp_q.push_back(mk(1'b0, 5'd3, 32'h0));
    for (int s = 0; s < 4; s++) begin
      get_txn(ok, got);
      e = exp_q.pop_front();
      checks++;
      if (!ok || got !== e) begin
        errors++;
        $display("FAIL restart_seq[%0d]: got wr=%0d addr=%0d data=%h ok=%0d, expected wr=%0d addr=%0d data=%h",
                 s, got.wr, got.addr, got.data, ok, e.wr, e.addr, e.data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rx();
    test_tx();
    test_alternate();
    test_overrun();
    test_cfg_div();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
